// File: rtl/z80_loader_pkg.sv
// rtl/z80_loader_pkg.sv - shared types and constants for the Z80 program ROM loader
package z80_loader_pkg;

  localparam int ROM_ADDR_W = 14;
  localparam int ROM_SIZE   = 16384;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_VWAIT  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/program_rom_loader.sv
// rtl/program_rom_loader.sv - streams bytes into the program ROM, optional checksum readback, gates Z80 reset
module program_rom_loader
  import z80_loader_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              verify_en,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              rom_ena,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_din,
  input  logic [7:0]        rom_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum,
  output logic              cpu_reset_n
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [RD_LAT-1:0] PIPE_LSB = {{(RD_LAT-1){1'b0}}, 1'b1};

  loader_state_t     state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic              ver_q;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   ret_cnt;
  logic [15:0]       vsum;
  logic [RD_LAT-1:0] vld_pipe;
  logic              ret_vld;
  logic              rd_issue;

  // The stream is accepted only while bytes of the current load remain.
  assign s_ready  = (state == ST_WRITE) && (wr_cnt < len_q);
  assign rd_issue = rom_ena && !rom_we;
  assign ret_vld  = vld_pipe[RD_LAT-1];

  // Tag each read on the ROM port so the return is summed RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | (rd_issue ? PIPE_LSB : '0);
    end
  end

  // Loader FSM with registered ROM port, status and CPU reset outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      ver_q       <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      ret_cnt     <= '0;
      vsum        <= '0;
      rom_ena     <= 1'b0;
      rom_we      <= 1'b0;
      rom_addr    <= '0;
      rom_din     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      checksum    <= '0;
      cpu_reset_n <= 1'b0;
    end else begin
      rom_ena <= 1'b0;
      rom_we  <= 1'b0;

      // Returns may still arrive after the last read issue, so sum in both phases.
      if (((state == ST_VERIFY) || (state == ST_VWAIT)) && ret_vld) begin
        vsum    <= vsum + {8'h00, rom_dout};
        ret_cnt <= ret_cnt + CNT_ONE;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            ver_q    <= verify_en;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            ret_cnt  <= '0;
            vsum     <= '0;
            checksum <= '0;
            error    <= 1'b0;
            if (length == '0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              cpu_reset_n <= 1'b1;
            end else begin
              state       <= ST_WRITE;
              done        <= 1'b0;
              busy        <= 1'b1;
              cpu_reset_n <= 1'b0;
            end
          end
        end

        ST_WRITE: begin
          if (s_valid && s_ready) begin
            rom_ena  <= 1'b1;
            rom_we   <= 1'b1;
            rom_addr <= base_q + wr_cnt[ADDR_W-1:0];
            rom_din  <= s_data;
            checksum <= checksum + {8'h00, s_data};
            wr_cnt   <= wr_cnt + CNT_ONE;
            if ((wr_cnt + CNT_ONE) == len_q) begin
              if (ver_q) begin
                state <= ST_VERIFY;
              end else begin
                state       <= ST_DONE;
                done        <= 1'b1;
                busy        <= 1'b0;
                cpu_reset_n <= 1'b1;
              end
            end
          end
        end

        ST_VERIFY: begin
          rom_ena  <= 1'b1;
          rom_addr <= base_q + rd_cnt[ADDR_W-1:0];
          rd_cnt   <= rd_cnt + CNT_ONE;
          if ((rd_cnt + CNT_ONE) == len_q) begin
            state <= ST_VWAIT;
          end
        end

        ST_VWAIT: begin
          if (ret_cnt == len_q) begin
            busy <= 1'b0;
            if (vsum == checksum) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state       <= ST_ERROR;
              error       <= 1'b1;
              cpu_reset_n <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
